ps2_scancode_decoder: RTL and testbench

//  Consumes scan-code set 2 bytes from the PS/2 keyboard receiver FIFO (data/ready/rdn interface).

---
 rtl/ps2_kb_pkg.sv | 55 +++++
 rtl/ps2_scancode_decoder.sv | 142 ++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_kb_pkg.sv
// Shared definitions for the PS/2 scan-code set 2 decoder: FSM states, special bytes
// and the table that maps the eight game keys onto key_state bits.
package ps2_kb_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DECODE
   } state_t;

   localparam logic [7:0] SC_E0     = 8'hE0;
   localparam logic [7:0] SC_F0     = 8'hF0;
   localparam logic [7:0] SC_E1     = 8'hE1;
   localparam logic [7:0] SC_ERR0   = 8'h00;
   localparam logic [7:0] SC_ERRF   = 8'hFF;
   localparam logic [7:0] SC_BAT    = 8'hAA;
   localparam logic [7:0] SC_ACK    = 8'hFA;
   localparam logic [7:0] SC_RESEND = 8'hFE;
   localparam logic [7:0] SC_ECHO   = 8'hEE;

   localparam logic [7:0] KEY_W     = 8'h1D;
   localparam logic [7:0] KEY_A     = 8'h1C;
   localparam logic [7:0] KEY_S     = 8'h1B;
   localparam logic [7:0] KEY_D     = 8'h23;
   localparam logic [7:0] KEY_SPACE = 8'h29;
   localparam logic [7:0] KEY_ENTER = 8'h5A;
   localparam logic [7:0] KEY_ESC   = 8'h76;
   localparam logic [7:0] KEY_P     = 8'h4D;

   // Remaining bytes of the Pause sequence after its leading E1.
   localparam logic [2:0] PAUSE_TAIL = 3'd7;

   // Returns {hit, idx}: hit=1 when code is one of the tracked game keys.
   function automatic logic [3:0] key_index(input logic [7:0] code);
      logic [3:0] r;
      case (code)
         KEY_W:     r = 4'b1_000;
         KEY_A:     r = 4'b1_001;
         KEY_S:     r = 4'b1_010;
         KEY_D:     r = 4'b1_011;
         KEY_SPACE: r = 4'b1_100;
         KEY_ENTER: r = 4'b1_101;
         KEY_ESC:   r = 4'b1_110;
         KEY_P:     r = 4'b1_111;
         default:   r = 4'b0_000;
      endcase
      return r;
   endfunction

   function automatic logic is_kbd_reply(input logic [7:0] code);
      return (code == SC_BAT) || (code == SC_ACK) ||
             (code == SC_RESEND) || (code == SC_ECHO);
   endfunction

endpackage

// File: rtl/ps2_scancode_decoder.sv
// Pops bytes from the PS/2 receiver FIFO, strips E0/F0/E1 prefixes, emits one event per
// completed make/break sequence and tracks the held state of eight game keys.
module ps2_scancode_decoder
   import ps2_kb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic [7:0] kb_data,
   input  logic       kb_ready,
   input  logic       kb_overflow,
   output logic       kb_rdn,
   output logic       ev_valid,
   output logic [7:0] ev_code,
   output logic       ev_ext,
   output logic       ev_break,
   output logic       ev_repeat,
   output logic [7:0] key_state
);

   localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q;
   logic             rdn_q;
   logic [7:0]       byte_q;
   logic             ext_q;
   logic             brk_q;
   logic [2:0]       skip_q;
   logic [TMR_W-1:0] timer_q;
   logic             ev_valid_q;
   logic [7:0]       ev_code_q;
   logic             ev_ext_q;
   logic             ev_brk_q;
   logic             ev_rep_q;
   logic [7:0]       keys_q;

   logic       key_hit;
   logic [2:0] key_idx;
   logic       tracked;
   logic       pending;

   always_comb begin
      {key_hit, key_idx} = key_index(byte_q);
      // Extended codes share byte values with game keys but are never tracked.
      tracked = key_hit && !ext_q;
      // A pending Pause tail also ages out, so a truncated sequence cannot swallow later keys.
      pending = ext_q || brk_q || (skip_q != 3'd0);
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         state_q    <= S_IDLE;
         rdn_q      <= 1'b1;
         byte_q     <= 8'h00;
         ext_q      <= 1'b0;
         brk_q      <= 1'b0;
         skip_q     <= 3'd0;
         timer_q    <= '0;
         ev_valid_q <= 1'b0;
         ev_code_q  <= 8'h00;
         ev_ext_q   <= 1'b0;
         ev_brk_q   <= 1'b0;
         ev_rep_q   <= 1'b0;
         keys_q     <= 8'h00;
      end else begin
         ev_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (kb_ready) begin
                  rdn_q   <= 1'b0;
                  state_q <= S_READ;
               end
            end
            S_READ: begin
               byte_q  <= kb_data;
               rdn_q   <= 1'b1;
               state_q <= S_DECODE;
            end
            S_DECODE: begin
               state_q <= S_IDLE;
               if (!kb_overflow) begin
                  if (skip_q != 3'd0) begin
                     skip_q <= skip_q - 3'd1;
                  end else if (byte_q == SC_E1) begin
                     skip_q <= PAUSE_TAIL;
                     ext_q  <= 1'b0;
                     brk_q  <= 1'b0;
                  end else if (byte_q == SC_ERR0 || byte_q == SC_ERRF) begin
                     ext_q <= 1'b0;
                     brk_q <= 1'b0;
                  end else if (is_kbd_reply(byte_q) && !ext_q && !brk_q) begin
                     ext_q <= 1'b0;
                  end else if (byte_q == SC_E0) begin
                     ext_q <= 1'b1;
                  end else if (byte_q == SC_F0) begin
                     brk_q <= 1'b1;
                  end else begin
                     ev_valid_q <= 1'b1;
                     ev_code_q  <= byte_q;
                     ev_ext_q   <= ext_q;
                     ev_brk_q   <= brk_q;
                     ev_rep_q   <= !brk_q && tracked && keys_q[key_idx];
                     if (tracked) keys_q[key_idx] <= !brk_q;
                     ext_q <= 1'b0;
                     brk_q <= 1'b0;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase

         if (state_q == S_READ || !pending) begin
            timer_q <= '0;
         end else if (timer_q == TMR_LAST) begin
            timer_q <= '0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            skip_q  <= 3'd0;
         end else begin
            timer_q <= timer_q + 1'b1;
         end

         if (kb_overflow) begin
            keys_q <= 8'h00;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            skip_q <= 3'd0;
         end
      end
   end

   assign kb_rdn    = rdn_q;
   assign ev_valid  = ev_valid_q;
   assign ev_code   = ev_code_q;
   assign ev_ext    = ev_ext_q;
   assign ev_break  = ev_brk_q;
   assign ev_repeat = ev_rep_q;
   assign key_state = keys_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: FIFO emulation, byte-level sequence model and
// directed scan-code scenarios.
module tb_ps2_scancode_decoder;

   localparam int unsigned TMO = 100;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic [7:0] kb_data = 8'h00;
   logic       kb_ready = 1'b0;
   logic       kb_overflow = 1'b0;
   logic       kb_rdn;
   logic       ev_valid;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_break;
   logic       ev_repeat;
   logic [7:0] key_state;

   ps2_scancode_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .clrn(clrn), .kb_data(kb_data), .kb_ready(kb_ready),
      .kb_overflow(kb_overflow), .kb_rdn(kb_rdn), .ev_valid(ev_valid),
      .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
      .ev_repeat(ev_repeat), .key_state(key_state)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic       rep;
      logic [7:0] keys;
   } ev_t;

   ev_t        exp_q[$];
   logic [7:0] trk[8] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h5A, 8'h76, 8'h4D};
   bit         m_ext = 0, m_brk = 0;
   int         m_skip = 0;
   logic [7:0] m_keys = 8'h00;

   task automatic model_byte(input logic [7:0] b);
      int  idx;
      ev_t e;
      idx = -1;
      if (m_skip > 0) m_skip--;
      else if (b == 8'hE1) begin m_skip = 7; m_ext = 0; m_brk = 0; end
      else if (b == 8'h00 || b == 8'hFF) begin m_ext = 0; m_brk = 0; end
      else if ((b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE) && !m_ext && !m_brk) begin
         m_skip = 0;
      end
      else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
         if (!m_ext) for (int i = 0; i < 8; i++) if (trk[i] == b) idx = i;
         e.code = b;
         e.ext  = m_ext;
         e.brk  = m_brk;
         e.rep  = (idx >= 0) && !m_brk && m_keys[idx];
         if (idx >= 0) m_keys[idx] = !m_brk;
         e.keys = m_keys;
         exp_q.push_back(e);
         m_ext = 0;
         m_brk = 0;
      end
   endtask

   task automatic model_clear_all(input bit keys_too);
      m_ext = 0; m_brk = 0; m_skip = 0;
      if (keys_too) m_keys = 8'h00;
   endtask

   // ---------------- FIFO emulation + per-cycle compare ----------------
   logic [7:0] fifo[$];
   bit         pop_pending = 0;
   bit         prev_low = 0;
   bit         prev_vld = 0;
   int         pushed = 0;
   int         low_cnt = 0;

   always @(negedge clk) begin
      ev_t got, want;
      if (pop_pending && fifo.size() != 0) void'(fifo.pop_front());
      pop_pending = (kb_rdn === 1'b0);
      if (kb_rdn === 1'b0) low_cnt++;
      check("kb_rdn_single_low", {31'd0, prev_low && (kb_rdn === 1'b0)}, 32'd0);
      prev_low = (kb_rdn === 1'b0);
      kb_ready = (fifo.size() != 0);
      kb_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;

      check("ev_valid_one_clk", {31'd0, prev_vld && (ev_valid === 1'b1)}, 32'd0);
      prev_vld = (ev_valid === 1'b1);
      if (ev_valid === 1'b1) begin
         got = {ev_code, ev_ext, ev_break, ev_repeat, key_state};
         if (exp_q.size() == 0) begin
            check("unexpected_event", {13'd0, got}, 32'd0);
         end else begin
            want = exp_q.pop_front();
            check("event{code,ext,brk,rep,keys}", {13'd0, got}, {13'd0, want});
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push(input logic [7:0] b);
      fifo.push_back(b);
      pushed++;
      model_byte(b);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((fifo.size() != 0 || pop_pending) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) check("drain_budget", 32'd1, 32'd0);
      repeat (4) @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_kb_rdn"}, {31'd0, kb_rdn}, 32'd1);
      check({tag, "_ev_valid"}, {31'd0, ev_valid}, 32'd0);
      check({tag, "_ev_code"}, {24'd0, ev_code}, 32'd0);
      check({tag, "_ev_ext"}, {31'd0, ev_ext}, 32'd0);
      check({tag, "_ev_break"}, {31'd0, ev_break}, 32'd0);
      check({tag, "_ev_repeat"}, {31'd0, ev_repeat}, 32'd0);
      check({tag, "_key_state"}, {24'd0, key_state}, 32'd0);
   endtask

   initial begin
      clrn = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      clrn = 1'b1;
      @(negedge clk);

      // A make then release
      push(8'h1C); drain();
      check("A_make_keys", {24'd0, key_state}, 32'h02);
      check("A_make_code", {24'd0, ev_code}, 32'h1C);
      push(8'hF0); push(8'h1C); drain();
      check("A_break_keys", {24'd0, key_state}, 32'h00);
      check("A_break_flag", {31'd0, ev_break}, 32'd1);

      // Extended key never tracked
      push(8'hE0); push(8'h75); drain();
      check("ext_make_ext", {31'd0, ev_ext}, 32'd1);
      push(8'hE0); push(8'hF0); push(8'h75); drain();
      check("ext_break_brk", {31'd0, ev_break}, 32'd1);
      check("ext_keys", {24'd0, key_state}, 32'h00);

      // Typematic repeat on W
      push(8'h1D); push(8'h1D); push(8'h1D); drain();
      check("W_repeat", {31'd0, ev_repeat}, 32'd1);
      check("W_keys", {24'd0, key_state}, 32'h01);
      push(8'hF0); push(8'h1D); drain();
      check("W_release", {24'd0, key_state}, 32'h00);
      check("W_release_rep", {31'd0, ev_repeat}, 32'd0);

      // Pause sequence swallowed, then Space
      push(8'hE1); push(8'h14); push(8'h77); push(8'hE1);
      push(8'hF0); push(8'h14); push(8'hF0); push(8'h77);
      push(8'h29); drain();
      check("pause_code", {24'd0, ev_code}, 32'h29);
      check("pause_keys", {24'd0, key_state}, 32'h10);
      push(8'hF0); push(8'h29); drain();

      // Keyboard replies ignored without prefix; error byte clears a pending F0
      push(8'hAA); push(8'hF0); push(8'h00); push(8'h1B); drain();
      check("err_clear_keys", {24'd0, key_state}, 32'h04);
      push(8'hF0); push(8'hAA); drain();
      check("reply_as_code", {24'd0, ev_code}, 32'hAA);
      push(8'hF0); push(8'h1B); drain();

      // Pending F0 ages out
      push(8'hF0); drain();
      repeat (TMO + 5) @(negedge clk);
      model_clear_all(1'b0);
      push(8'h23); drain();
      check("timeout_brk", {31'd0, ev_break}, 32'd0);
      check("timeout_keys", {24'd0, key_state}, 32'h08);
      push(8'hF0); push(8'h23); drain();

      // Overflow drops held keys
      push(8'h1D); push(8'h1C); drain();
      check("hold_WA", {24'd0, key_state}, 32'h03);
      kb_overflow = 1'b1;
      @(negedge clk);
      kb_overflow = 1'b0;
      model_clear_all(1'b1);
      check("overflow_keys", {24'd0, key_state}, 32'h00);
      @(negedge clk);

      // Reset in the middle of E0 F0 discards the prefixes
      push(8'h5A); push(8'hE0); push(8'hF0); drain();
      check("enter_keys", {24'd0, key_state}, 32'h20);
      clrn = 1'b0;
      @(negedge clk);
      check_reset_values("midseq_reset");
      model_clear_all(1'b1);
      clrn = 1'b1;
      @(negedge clk);
      push(8'h76); drain();
      check("post_reset_ext", {31'd0, ev_ext}, 32'd0);
      check("post_reset_keys", {24'd0, key_state}, 32'h40);

      check("events_outstanding", exp_q.size(), 32'd0);
      check("pops_vs_bytes", low_cnt, pushed);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: got expired expected finish");
      $fatal(1, "time limit");
   end

endmodule
